// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants, stall vectors and FSM encoding for mem_port_arbiter.
// Stall bit order: 0=pc 1=if_id 2=id_ex 3=ex_mem 4=mem_wb 5=wb.
package mem_port_arbiter_pkg;

    localparam logic Stop       = 1'b1;
    localparam logic NoStop     = 1'b0;

    localparam logic ReqEnable  = 1'b1;
    localparam logic ReqDisable = 1'b0;

    localparam logic [5:0] StallNone = {6{NoStop}};
    localparam logic [5:0] StallIf   = {{4{NoStop}}, {2{Stop}}};
    localparam logic [5:0] StallId   = {{3{NoStop}}, {3{Stop}}};
    localparam logic [5:0] StallEx   = {{2{NoStop}}, {4{Stop}}};
    localparam logic [5:0] StallMem  = {NoStop, {5{Stop}}};

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        IF_WAIT  = 2'd1,
        MEM_WAIT = 2'd2,
        RESP     = 2'd3
    } arb_state_t;

    // Ack-timeout counter is never narrower than 4 bits.
    function automatic int counter_width(input int max_wait);
        int w;
        w = $clog2(max_wait + 1);
        return (w > 4) ? w : 4;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_stall_encoder.sv
// Priority encoder turning pending memory traffic and stage stall requests
// into the six-bit pipeline stall vector.
module mem_port_arbiter_stall_encoder
    import mem_port_arbiter_pkg::*;
(
    input  logic       mem_pending,
    input  logic       if_pending,
    input  logic       stallreq_ex,
    input  logic       stallreq_id,
    output logic [5:0] stall
);

    always_comb begin
        stall = StallNone;
        if (mem_pending) begin
            stall = StallMem;
        end else if (stallreq_ex) begin
            stall = StallEx;
        end else if (stallreq_id) begin
            stall = StallId;
        end else if (if_pending) begin
            stall = StallIf;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single external memory port between fetch and data access.
// Optional ack timeout is enabled by defining TIMEOUT_EN.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 15
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic [DATA_W-1:0]   if_rdata,
    output logic                if_done,
    input  logic                mem_req,
    input  logic                mem_we,
    input  logic [ADDR_W-1:0]   mem_addr,
    input  logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W/8-1:0] mem_sel,
    output logic [DATA_W-1:0]   mem_rdata,
    output logic                mem_done,
    input  logic                stallreq_id,
    input  logic                stallreq_ex,
    output logic                bus_req,
    output logic                bus_we,
    output logic [ADDR_W-1:0]   bus_addr,
    output logic [DATA_W-1:0]   bus_wdata,
    output logic [DATA_W/8-1:0] bus_sel,
    input  logic [DATA_W-1:0]   bus_rdata,
    input  logic                bus_ack,
    output logic [5:0]          stall,
    output logic                bus_err
);

    arb_state_t  state;
    arb_state_t  state_next;
    logic        owner_mem;
    logic        grant_mem;
    logic        grant_if;
    logic        complete;
    logic        expire;
    logic        in_wait;
    logic        timeout_hit;
    logic        mem_pending;
    logic        if_pending;
    logic [5:0]  stall_enc;

    assign in_wait = (state == IF_WAIT) || (state == MEM_WAIT);

    // Data side wins a simultaneous request; RESP ignores all requests.
    always_comb begin
        state_next = state;
        grant_mem  = 1'b0;
        grant_if   = 1'b0;
        complete   = 1'b0;
        expire     = 1'b0;
        case (state)
            IDLE: begin
                if (mem_req) begin
                    grant_mem  = 1'b1;
                    state_next = MEM_WAIT;
                end else if (if_req) begin
                    grant_if   = 1'b1;
                    state_next = IF_WAIT;
                end
            end
            IF_WAIT, MEM_WAIT: begin
                if (bus_ack) begin
                    complete   = 1'b1;
                    state_next = RESP;
                end else if (timeout_hit) begin
                    expire     = 1'b1;
                    state_next = RESP;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            owner_mem <= 1'b0;
            bus_req   <= ReqDisable;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            bus_sel   <= '0;
            if_rdata  <= '0;
            mem_rdata <= '0;
        end else begin
            state <= state_next;
            if (grant_mem) begin
                owner_mem <= 1'b1;
                bus_req   <= ReqEnable;
                bus_we    <= mem_we;
                bus_addr  <= mem_addr;
                bus_wdata <= mem_wdata;
                bus_sel   <= mem_sel;
            end else if (grant_if) begin
                owner_mem <= 1'b0;
                bus_req   <= ReqEnable;
                bus_we    <= 1'b0;
                bus_addr  <= if_addr;
                bus_wdata <= '0;
                bus_sel   <= '1;
            end
            // A timed-out transaction returns zero rather than stale bus data.
            if (complete || expire) begin
                bus_req <= ReqDisable;
                if (owner_mem) begin
                    mem_rdata <= complete ? bus_rdata : '0;
                end else begin
                    if_rdata  <= complete ? bus_rdata : '0;
                end
            end
        end
    end

`ifdef TIMEOUT_EN
    localparam int CNT_W = counter_width(MAX_WAIT);

    logic [CNT_W-1:0] wait_cnt;
    logic             timed_out;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt  <= '0;
            timed_out <= 1'b0;
        end else begin
            if (grant_mem || grant_if) begin
                wait_cnt <= '0;
            end else if (in_wait && !bus_ack) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            timed_out <= expire;
        end
    end

    // Fires on the MAX_WAIT-th wait cycle; a same-cycle ack takes precedence.
    assign timeout_hit = in_wait && !bus_ack && (wait_cnt == CNT_W'(MAX_WAIT - 1));
    assign bus_err     = (state == RESP) && timed_out;
`else
    localparam int max_wait_unused = MAX_WAIT;

    assign timeout_hit = 1'b0;
    assign bus_err     = 1'b0;
`endif

    assign mem_done    = (state == RESP) && owner_mem;
    assign if_done     = (state == RESP) && !owner_mem;
    assign mem_pending = mem_req && !mem_done;
    assign if_pending  = if_req && !if_done;

    mem_port_arbiter_stall_encoder u_stall_encoder (
        .mem_pending (mem_pending),
        .if_pending  (if_pending),
        .stallreq_ex (stallreq_ex),
        .stallreq_id (stallreq_id),
        .stall       (stall_enc)
    );

    // Reset forces the stall vector low even while requesters still hold req.
    assign stall = rst ? stall_enc : StallNone;

endmodule
